// File: rtl/fifo_ptr_pkg.sv
// fifo_ptr_pkg: shared helpers for async-FIFO Gray pointer encode/decode.
package fifo_ptr_pkg;
  localparam int MIN_SYNC_STAGES = 2;
  // Operands are zero-extended to 32 bits, so the upper bits never disturb the prefix XOR.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic onehot_or_zero(input logic [31:0] x);
    return (x & (x - 32'd1)) == 32'd0;
  endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary decoder, inverse of the pointer encoder.
module gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  assign bin = WIDTH'(fifo_ptr_pkg::gray2bin(32'(gray)));
endmodule

// File: rtl/gray_ptr_decoder.sv
// gray_ptr_decoder: synchronizes a remote Gray pointer, decodes it, flags multi-bit
// jumps and derives level/empty/full against the local binary pointer.
module gray_ptr_decoder
  import fifo_ptr_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic [WIDTH-1:0] local_bin,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_upd,
  output logic [WIDTH-1:0] level,
  output logic             empty,
  output logic             full,
  output logic             err_multibit
);
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
  if (SYNC_STAGES < MIN_SYNC_STAGES || WIDTH < 2) begin : g_bad_params
    $error("gray_ptr_decoder: WIDTH and SYNC_STAGES must both be at least 2");
  end
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_g, prev_g, dec;
  assign sync_g = sync_q[SYNC_STAGES-1];
  gray2bin #(.WIDTH(WIDTH)) u_dec (.gray(sync_g), .bin(dec));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_g       <= '0;
      bin_out      <= '0;
      bin_upd      <= 1'b0;
      err_multibit <= 1'b0;
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_g  <= sync_g;
      bin_out <= dec;
      bin_upd <= sync_g != prev_g;
      // A detected jump wins over a simultaneous clear so no error is ever lost.
      if (!onehot_or_zero(32'(sync_g ^ prev_g))) err_multibit <= 1'b1;
      else if (err_clr) err_multibit <= 1'b0;
    end
  end
  assign level = bin_out - local_bin;
  assign empty = level == '0;
  assign full  = level == HALF;
endmodule

// File: doc/gray_ptr_decoder.md
# gray_ptr_decoder

Destination-side companion to the binary-to-Gray pointer encoder in the asynchronous FIFO. It captures a Gray-coded pointer arriving from the other clock domain through a multi-flop synchronizer and decodes it to binary. It also flags any illegal multi-bit Gray transition, and derives occupancy, empty and full against the local binary pointer. One instance per direction: the write pointer into the read domain, and the read pointer into the write domain.

## Interface
Parameters:
- WIDTH, 4: pointer width including the wrap bit; FIFO depth is 2^(WIDTH-1); WIDTH ≥ 2.
- SYNC_STAGES, 2: synchronizer depth; SYNC_STAGES ≥ 2.

Ports:
- clk  in  1  destination-domain clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- gray_in  in  WIDTH  Gray pointer from the source domain; asynchronous to clk.
- local_bin  in  WIDTH  local binary pointer, synchronous to clk.
- err_clr  in  1  clears err_multibit.
- bin_out  out  WIDTH  decoded binary remote pointer, registered.
- bin_upd  out  1  one-cycle pulse in the cycle bin_out takes a new value.
- level  out  WIDTH  (bin_out − local_bin) mod 2^WIDTH, combinational from registered bin_out and local_bin.
- empty  out  1  level == 0.
- full  out  1  level == 2^(WIDTH-1).
- err_multibit  out  1  sticky flag: a synchronized Gray word differed from the previous one in more than 1 bit.

## Operation
- Synchronizer: a chain of SYNC_STAGES WIDTH-bit registers. Stage 0 samples gray_in, and each stage feeds the next. The last stage is sync_g.
- Decode register: holds the previous sync_g value, prev_g.
- Every cycle, bin_out ← gray2bin(sync_g).
- gray2bin: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i < WIDTH-1.
- bin_upd ← (sync_g != prev_g); prev_g ← sync_g.
- Multi-bit check: if popcount(sync_g ^ prev_g) > 1, err_multibit ← 1 on the same edge that updates bin_out.
  - bin_out still updates to the decoded value; the error is reported only, never masked.
- err_clr = 1 clears err_multibit on the next edge. If a set condition and err_clr occur in the same cycle, set wins.
- Arithmetic: level is a WIDTH-bit modular subtraction with no saturation.
  - level > 2^(WIDTH-1) is never produced by a legal FIFO; it is passed through unflagged.
- Wrap-around: Gray 100…0 → 000…0 is a single-bit change. bin_out goes 2^WIDTH−1 → 0 with no error.
- No state machine; the block is purely pipelined.

## Timing
- Reset (rst_n low, asynchronous, any time including mid-transfer):
  - All synchronizer stages, prev_g, bin_out and err_multibit go to 0; bin_upd goes to 0.
  - level = (0 − local_bin) mod 2^WIDTH; empty = (local_bin == 0).
- Deassertion is taken synchronously to clk by the surrounding reset logic; this block contains no reset synchronizer.
- Latency: a gray_in change settled before clock edge N appears on bin_out, with bin_upd = 1, after edge N+SYNC_STAGES. That is 3 edges at the default (2 sync stages plus 1 decode register).
- err_multibit asserts in the same cycle as the offending bin_upd.
- level, empty and full follow bin_out and local_bin with zero additional latency.
- Back-to-back changes: each synchronized change produces one bin_upd pulse, so consecutive changes give consecutive pulses.

## Structure
- Shared package fifo_ptr_pkg:
  - function gray2bin(WIDTH), which is the inverse of the existing encoder.
  - function onehot_or_zero, used for the multi-bit check.
  - constant MIN_SYNC_STAGES = 2.
- Sub-module gray2bin: a parameterized combinational decoder mirroring the encoder's interface, instantiated once on sync_g.
- Elaboration-time check rejects SYNC_STAGES < 2 and WIDTH < 2.

## Test plan
All cases use WIDTH=4, SYNC_STAGES=2.
- Reset: drive rst_n=0 mid-stream with gray_in=0110 and local_bin=0 → immediately bin_out=0, bin_upd=0, err_multibit=0, empty=1, full=0.
- Latency and decode: gray_in steps 0000→0001→0011→0010, one step per 4 cycles → bin_out becomes 1, 2, 3, each exactly 3 edges after the step, with one bin_upd pulse each and err_multibit=0.
- Wrap and level: local_bin=15, gray_in 1000 (bin 15) → 0000 → bin_out goes 15→0, level goes 0→1, empty goes 1→0, no error.
- Full: local_bin=0, gray_in=1100 (bin 8) → level=8, full=1, empty=0.
- Multi-bit error: gray_in 0000→0011 → bin_out=2, err_multibit=1 in the same cycle as bin_upd.
  - err_clr pulse alone → err_multibit=0 next cycle.
  - err_clr coincident with a new 0011→0101 jump → err_multibit stays 1.
- Full sequence: gray_in walks all 16 codes in order, then repeats, with local_bin tracking 2 behind → bin_out matches the counter, level=2 throughout, 16 bin_upd pulses per lap, no error.
